ram_wb_burst: RTL and testbench

Wishbone B3 registered-feedback SRAM slave, successor to the single-width classic-cycle RAM slave used on the AC97 system bus. Adds parametrised data width with byte selects, zero-wait-state CTI/BTE bursts (constant, linear, wrap-4/8/16), and an `err_o` response for out-of-range addresses. Sits on the shared Wishbone interconnect as a code/data or sample-buffer memory.

---
 rtl/ram_wb_pkg.sv | 46 ++++
 rtl/ram_wb_burst_if.sv | 30 +++
 rtl/ram_be.sv | 36 +++
 rtl/ram_wb_burst.sv | 121 ++++++++++++
 tb/tb_ram_wb_burst.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_wb_pkg.sv
// ram_wb_pkg: shared constants, FSM state encoding and burst address helper
// for the ram_wb_burst Wishbone SRAM slave.
//   CTI_*      : Wishbone cycle type identifiers understood by the slave
//   BTE_*      : burst type extensions (linear, wrap-4/8/16)
//   state_t    : slave FSM states
//   burst_next : next word address of an incrementing burst
package ram_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Fixed working width for burst_next; callers zero-extend their word
  // address and keep as many result bits as they need (one extra bit
  // catches a linear carry out of the top of the address range).
  localparam int BURST_ADR_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // Wrap modes increment only the low 2/3/4 bits; upper bits stay put.
  function automatic logic [BURST_ADR_W-1:0] burst_next(
    input logic [BURST_ADR_W-1:0] adr,
    input logic [1:0]             bte
  );
    logic [BURST_ADR_W-1:0] nxt;
    nxt = adr;
    case (bte)
      BTE_LINEAR: nxt = adr + BURST_ADR_W'(1);
      BTE_WRAP4:  nxt[1:0] = adr[1:0] + 2'd1;
      BTE_WRAP8:  nxt[2:0] = adr[2:0] + 3'd1;
      default:    nxt[3:0] = adr[3:0] + 4'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ram_wb_burst_if.sv
// ram_wb_burst_if: Wishbone B3 bus bundle between a master and the
// ram_wb_burst slave. Signal names keep the slave-side _i/_o suffixes.
//   adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, cti_i, bte_i : master -> slave
//   dat_o, ack_o, err_o                                   : slave -> master
interface ram_wb_burst_if #(
  parameter int DAT_WIDTH = 32,
  parameter int ADR_WIDTH = 24
);
  logic [ADR_WIDTH-1:0]   adr_i;
  logic [DAT_WIDTH-1:0]   dat_i;
  logic [DAT_WIDTH-1:0]   dat_o;
  logic [DAT_WIDTH/8-1:0] sel_i;
  logic                   we_i;
  logic                   cyc_i;
  logic                   stb_i;
  logic [2:0]             cti_i;
  logic [1:0]             bte_i;
  logic                   ack_o;
  logic                   err_o;

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, cti_i, bte_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, cti_i, bte_i,
    input  dat_o, ack_o, err_o
  );
endinterface

// File: rtl/ram_be.sv
// ram_be: synchronous RAM with per-byte write enables and a registered read.
// A read and a write to the same word on one edge return the old data; the
// written value is visible to any read on a later edge.
//   i_clk    : clock
//   i_we_b   : byte write enables (one per 8-bit lane)
//   i_wr_adr : write word address
//   i_wr_dat : write data
//   i_rd_adr : read word address, sampled on the rising edge
//   o_rd_dat : registered read data
module ram_be #(
  parameter int DAT_WIDTH = 32,
  parameter int DEPTH     = 2048,
  parameter int ADR_W     = 11,
  parameter     INIT_FILE = ""
) (
  input  logic                   i_clk,
  input  logic [DAT_WIDTH/8-1:0] i_we_b,
  input  logic [ADR_W-1:0]       i_wr_adr,
  input  logic [DAT_WIDTH-1:0]   i_wr_dat,
  input  logic [ADR_W-1:0]       i_rd_adr,
  output logic [DAT_WIDTH-1:0]   o_rd_dat
);
  localparam int NB = DAT_WIDTH / 8;

  logic [NB-1:0][7:0]   r_mem [DEPTH];
  logic [DAT_WIDTH-1:0] r_rd_dat;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we_b[b]) r_mem[i_wr_adr][b] <= i_wr_dat[8*b +: 8];
    end
    r_rd_dat <= r_mem[i_rd_adr];
  end

  assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/ram_wb_burst.sv
// ram_wb_burst: Wishbone B3 registered-feedback SRAM slave with byte
// selects, zero-wait CTI/BTE bursts and an error response for addresses
// beyond the memory.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   wb      : Wishbone slave bundle (see ram_wb_burst_if)
//
//   state   | meaning
//   --------+------------------------------------------------------
//   ST_IDLE | no response pending, waiting for cyc_i & stb_i
//   ST_BEAT | ack_o high, one data beat per cycle
//   ST_ERR  | err_o high for one cycle, then back to ST_IDLE
module ram_wb_burst
  import ram_wb_pkg::*;
#(
  parameter int DAT_WIDTH     = 32,
  parameter int ADR_WIDTH     = 24,
  parameter int MEM_WORDS     = 2048,
  parameter     MEM_INIT_FILE = ""
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  ram_wb_burst_if.slave wb
);
  localparam int NB  = DAT_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam int WA  = ADR_WIDTH - OFS;
  localparam int RA  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // One bit wider than a word address so a full power-of-two depth and a
  // linear carry out of the top both compare correctly.
  localparam logic [WA:0] MEM_LIM = (WA+1)'(MEM_WORDS);

  state_t                 r_state, w_state_nxt;
  logic [WA-1:0]          r_adr_q, w_adr_nxt;
  logic [WA-1:0]          w_req_word, w_rd_word;
  logic [WA:0]            w_nxt;
  logic [BURST_ADR_W-1:0] w_burst_full;
  logic                   r_ack, r_err;
  logic                   w_req, w_beat;
  logic [NB-1:0]          w_we_b;
  logic [DAT_WIDTH-1:0]   w_rd_dat;
  logic                   w_unused;

  assign w_req        = wb.cyc_i & wb.stb_i;
  assign w_req_word   = wb.adr_i[ADR_WIDTH-1:OFS];
  assign w_burst_full = burst_next(BURST_ADR_W'(r_adr_q), wb.bte_i);

  always_comb begin
    w_nxt = {1'b0, r_adr_q};
    if (wb.cti_i == CTI_INCR) w_nxt = w_burst_full[WA:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_adr_nxt   = r_adr_q;
    w_rd_word   = w_req_word;
    w_beat      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_adr_nxt   = w_req_word;
          w_state_nxt = ({1'b0, w_req_word} >= MEM_LIM) ? ST_ERR : ST_BEAT;
        end
      end
      ST_BEAT: begin
        // A beat without strobe ends the cycle; the master restarts from adr_i.
        w_state_nxt = ST_IDLE;
        if (w_req) begin
          w_beat = 1'b1;
          if (wb.cti_i == CTI_CONST || wb.cti_i == CTI_INCR) begin
            if (w_nxt >= MEM_LIM) begin
              w_state_nxt = ST_ERR;
            end else begin
              w_state_nxt = ST_BEAT;
              w_adr_nxt   = w_nxt[WA-1:0];
              w_rd_word   = w_nxt[WA-1:0];
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_adr_q <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_adr_q <= w_adr_nxt;
      r_ack   <= (w_state_nxt == ST_BEAT);
      r_err   <= (w_state_nxt == ST_ERR);
    end
  end

  assign w_we_b = {NB{w_beat & wb.we_i}} & wb.sel_i;

  ram_be #(
    .DAT_WIDTH (DAT_WIDTH),
    .DEPTH     (MEM_WORDS),
    .ADR_W     (RA),
    .INIT_FILE (MEM_INIT_FILE)
  ) u_ram (
    .i_clk    (clk_i),
    .i_we_b   (w_we_b),
    .i_wr_adr (r_adr_q[RA-1:0]),
    .i_wr_dat (wb.dat_i),
    .i_rd_adr (w_rd_word[RA-1:0]),
    .o_rd_dat (w_rd_dat)
  );

  assign wb.ack_o = r_ack;
  assign wb.err_o = r_err;
  // RAM output register holds stale words outside a beat; present zero then.
  assign wb.dat_o = r_ack ? w_rd_dat : '0;

  assign w_unused = ^{w_burst_full, wb.adr_i, w_rd_word};
endmodule

// File: tb/tb_ram_wb_burst.sv
module tb_ram_wb_burst;
  import ram_wb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 24;
  localparam int WORDS = 16;

  // {cyc, stb, we}
  localparam logic [2:0] C_W = 3'b111;
  localparam logic [2:0] C_R = 3'b110;
  localparam logic [2:0] C_D = 3'b101;
  localparam logic [2:0] C_I = 3'b000;
  // {ack, err, check dat}
  localparam logic [2:0] R_AN = 3'b100;
  localparam logic [2:0] R_AD = 3'b101;
  localparam logic [2:0] R_NO = 3'b001;
  localparam logic [2:0] R_ER = 3'b011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_wb_burst_if #(.DAT_WIDTH(DW), .ADR_WIDTH(AW)) wb();

  ram_wb_burst #(
    .DAT_WIDTH(DW), .ADR_WIDTH(AW), .MEM_WORDS(WORDS), .MEM_INIT_FILE("")
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb(wb)
  );

  typedef struct {
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [23:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack, err, dchk;
    logic [31:0] dexp;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic [2:0] ctl, input logic [2:0] cti,
                              input logic [1:0] bte, input logic [23:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel,
                              input logic [2:0] rsp, input logic [31:0] dexp);
    vec_t v;
    v.cyc = ctl[2]; v.stb = ctl[1]; v.we = ctl[0];
    v.cti = cti; v.bte = bte; v.adr = adr; v.dat = dat; v.sel = sel;
    v.ack = rsp[2]; v.err = rsp[1]; v.dchk = rsp[0];
    v.dexp = dexp;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(C_I, CTI_CLASSIC, BTE_LINEAR, 24'h0, 32'h0, 4'h0, R_NO, 32'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb.cyc_i = v.cyc; wb.stb_i = v.stb; wb.we_i = v.we;
    wb.cti_i = v.cti; wb.bte_i = v.bte; wb.adr_i = v.adr;
    wb.dat_i = v.dat; wb.sel_i = v.sel;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    drive(v);
    @(posedge clk);
    #1;
    check({tag, "_ack"}, 32'(wb.ack_o), 32'(v.ack));
    check({tag, "_err"}, 32'(wb.err_o), 32'(v.err));
    if (v.dchk) check({tag, "_dat"}, wb.dat_o, v.dexp);
  endtask

  task automatic read_word(input logic [23:0] adr, input logic [31:0] exp, input string tag);
    run_row(mk(C_R, CTI_CLASSIC, BTE_LINEAR, adr, 32'h0, 4'hF, R_AD, exp), tag);
    run_row(mk(C_R, CTI_CLASSIC, BTE_LINEAR, adr, 32'h0, 4'hF, R_NO, 32'h0), {tag, "_end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // classic write then read, word 4
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h10, 32'hDEADBEEF, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h10, 32'hDEADBEEF, 4'hF, R_NO, 32'h0));
    vecs.push_back(idle());
    vecs.push_back(mk(C_R, CTI_CLASSIC, BTE_LINEAR, 24'h10, 32'h0, 4'hF, R_AD, 32'hDEADBEEF));
    vecs.push_back(mk(C_R, CTI_CLASSIC, BTE_LINEAR, 24'h10, 32'h0, 4'hF, R_NO, 32'h0));
    // byte lanes, word 8
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h20, 32'hAABBCCDD, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h20, 32'hAABBCCDD, 4'hF, R_NO, 32'h0));
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h20, 32'h11223344, 4'h5, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h20, 32'h11223344, 4'h5, R_NO, 32'h0));
    vecs.push_back(mk(C_R, CTI_CLASSIC, BTE_LINEAR, 24'h20, 32'h0, 4'hF, R_AD, 32'hAA22CC44));
    vecs.push_back(mk(C_R, CTI_CLASSIC, BTE_LINEAR, 24'h20, 32'h0, 4'hF, R_NO, 32'h0));
    // constant-address read burst, word 8
    vecs.push_back(mk(C_R, CTI_CONST, BTE_LINEAR, 24'h20, 32'h0, 4'hF, R_AD, 32'hAA22CC44));
    vecs.push_back(mk(C_R, CTI_CONST, BTE_LINEAR, 24'h20, 32'h0, 4'hF, R_AD, 32'hAA22CC44));
    vecs.push_back(mk(C_R, CTI_EOB,   BTE_LINEAR, 24'h20, 32'h0, 4'hF, R_NO, 32'h0));
    // linear write burst, words 4..7
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h10, 32'h11110004, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h10, 32'h11110004, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h14, 32'h11110005, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h18, 32'h11110006, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_EOB,  BTE_LINEAR, 24'h1C, 32'h11110007, 4'hF, R_NO, 32'h0));
    // wrap-4 read burst from word 6: 6,7,4,5
    vecs.push_back(mk(C_R, CTI_INCR, BTE_WRAP4, 24'h18, 32'h0, 4'hF, R_AD, 32'h11110006));
    vecs.push_back(mk(C_R, CTI_INCR, BTE_WRAP4, 24'h1C, 32'h0, 4'hF, R_AD, 32'h11110007));
    vecs.push_back(mk(C_R, CTI_INCR, BTE_WRAP4, 24'h10, 32'h0, 4'hF, R_AD, 32'h11110004));
    vecs.push_back(mk(C_R, CTI_INCR, BTE_WRAP4, 24'h14, 32'h0, 4'hF, R_AD, 32'h11110005));
    vecs.push_back(mk(C_R, CTI_EOB,  BTE_WRAP4, 24'h18, 32'h0, 4'hF, R_NO, 32'h0));
    // word 0 reference value
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h00, 32'h0BADF00D, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h00, 32'h0BADF00D, 4'hF, R_NO, 32'h0));
    // linear overrun from word 15: beat 1 acked, beat 2 errors
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h3C, 32'hCAFE000F, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h3C, 32'hCAFE000F, 4'hF, R_ER, 32'h0));
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h40, 32'hFFFFFFFF, 4'hF, R_NO, 32'h0));
    vecs.push_back(idle());
    // classic write to word 16 (out of range)
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h40, 32'hFFFFFFFF, 4'hF, R_ER, 32'h0));
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h40, 32'hFFFFFFFF, 4'hF, R_NO, 32'h0));
    vecs.push_back(idle());
    vecs.push_back(mk(C_R, CTI_CLASSIC, BTE_LINEAR, 24'h3C, 32'h0, 4'hF, R_AD, 32'hCAFE000F));
    vecs.push_back(mk(C_R, CTI_CLASSIC, BTE_LINEAR, 24'h3C, 32'h0, 4'hF, R_NO, 32'h0));
    vecs.push_back(mk(C_R, CTI_CLASSIC, BTE_LINEAR, 24'h00, 32'h0, 4'hF, R_AD, 32'h0BADF00D));
    vecs.push_back(mk(C_R, CTI_CLASSIC, BTE_LINEAR, 24'h00, 32'h0, 4'hF, R_NO, 32'h0));
    // strobe drop mid write-burst, then restart at word 12
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h2C, 32'h5555000B, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h2C, 32'h5555000B, 4'hF, R_NO, 32'h0));
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h28, 32'h2222000A, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h28, 32'h2222000A, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_D, CTI_INCR, BTE_LINEAR, 24'h2C, 32'hBAD0000B, 4'hF, R_NO, 32'h0));
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h30, 32'h3333000C, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h30, 32'h3333000C, 4'hF, R_AN, 32'h0));
    vecs.push_back(mk(C_W, CTI_EOB,  BTE_LINEAR, 24'h34, 32'h3333000D, 4'hF, R_NO, 32'h0));
    // linear read burst words 10..13
    vecs.push_back(mk(C_R, CTI_INCR, BTE_LINEAR, 24'h28, 32'h0, 4'hF, R_AD, 32'h2222000A));
    vecs.push_back(mk(C_R, CTI_INCR, BTE_LINEAR, 24'h2C, 32'h0, 4'hF, R_AD, 32'h5555000B));
    vecs.push_back(mk(C_R, CTI_INCR, BTE_LINEAR, 24'h30, 32'h0, 4'hF, R_AD, 32'h3333000C));
    vecs.push_back(mk(C_R, CTI_INCR, BTE_LINEAR, 24'h34, 32'h0, 4'hF, R_AD, 32'h3333000D));
    vecs.push_back(mk(C_R, CTI_EOB,  BTE_LINEAR, 24'h38, 32'h0, 4'hF, R_NO, 32'h0));
    vecs.push_back(idle());

    // reset state
    drive(idle());
    rst_n = 1'b0;
    #1;
    check("reset_ack", 32'(wb.ack_o), 32'h0);
    check("reset_err", 32'(wb.err_o), 32'h0);
    check("reset_dat", wb.dat_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_row(vecs[i], $sformatf("row%0d", i));
    end

    // reset pulse in the middle of a write burst from word 1
    run_row(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h08, 32'h66660002, 4'hF, R_AN, 32'h0), "pre2_req");
    run_row(mk(C_W, CTI_CLASSIC, BTE_LINEAR, 24'h08, 32'h66660002, 4'hF, R_NO, 32'h0), "pre2_end");
    run_row(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h04, 32'h77770001, 4'hF, R_AN, 32'h0), "rb_req");
    run_row(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h04, 32'h77770001, 4'hF, R_AN, 32'h0), "rb_beat1");
    drive(mk(C_W, CTI_INCR, BTE_LINEAR, 24'h08, 32'h77770002, 4'hF, R_NO, 32'h0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rb_async_ack", 32'(wb.ack_o), 32'h0);
    check("rb_async_err", 32'(wb.err_o), 32'h0);
    check("rb_async_dat", wb.dat_o, 32'h0);
    @(posedge clk);
    #1;
    check("rb_held_ack", 32'(wb.ack_o), 32'h0);
    drive(idle());
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    read_word(24'h04, 32'h77770001, "rb_w1");
    read_word(24'h08, 32'h66660002, "rb_w2");
    read_word(24'h00, 32'h0BADF00D, "rb_w0");
    read_word(24'h10, 32'h11110004, "rb_w4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
